// File: rtl/irq_sched_pkg.sv
// Shared types, default sizes and helpers for the interrupt coalescing scheduler.
package irq_sched_pkg;

    localparam int unsigned DEF_N_SOURCES = 4;
    localparam int unsigned DEF_CNT_WIDTH = 16;
    localparam int unsigned MAX_SOURCES   = 32;
    localparam int unsigned POP_W         = 6;   // holds 0..32
    localparam int unsigned TIMER_W       = 32;

    typedef enum logic [1:0] {
        IDLE_ST    = 2'd0,
        COLLECT_ST = 2'd1,
        ASSERT_ST  = 2'd2
    } fsm_e;

    // Number of set bits; callers zero-extend their N_SOURCES-wide vector.
    function automatic logic [POP_W-1:0] popcount(input logic [MAX_SOURCES-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(MAX_SOURCES); i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/irq_sat_counter.sv
// Saturating event accumulator: adds add_i each cycle, or restarts from add_i on load_i.
module irq_sat_counter
    import irq_sched_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int unsigned ADD_WIDTH = POP_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [ADD_WIDTH-1:0] add_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    localparam int unsigned SUM_W = CNT_WIDTH + ADD_WIDTH;

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic [SUM_W-1:0]     base;
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     max_ext;

    // Next count: base (0 on load) plus add value, clamped to all-ones.
    always_comb begin
        max_ext = SUM_W'({CNT_WIDTH{1'b1}});
        base    = load_i ? '0 : SUM_W'(count_q);
        sum     = base + SUM_W'(add_i);
        count_d = (sum > max_ext) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/irq_coalescing_scheduler.sv
// Interrupt moderation: gathers event pulses into sticky pending bits and a count,
// raises one level IRQ on threshold or timeout, and clears on a W1C acknowledge.
module irq_coalescing_scheduler
    import irq_sched_pkg::*;
#(
    parameter int unsigned N_SOURCES = DEF_N_SOURCES,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_SOURCES-1:0] event_i,
    input  logic [N_SOURCES-1:0] mask_i,
    input  logic [CNT_WIDTH-1:0] threshold_i,
    input  logic [TIMER_W-1:0]   timeout_i,
    input  logic                 ack_i,
    input  logic [N_SOURCES-1:0] ack_mask_i,
    output logic [N_SOURCES-1:0] pending_o,
    output logic [CNT_WIDTH-1:0] event_count_o,
    output logic                 irq_o
);

    fsm_e                 state_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 irq_q;
    logic [N_SOURCES-1:0] pending_q;

    logic [N_SOURCES-1:0] acc;
    logic [POP_W-1:0]     acc_cnt;
    logic [N_SOURCES-1:0] pending_d;
    logic                 thresh_hit;
    logic                 timeout_hit;

    // Accepted events, next pending vector and fire conditions.
    always_comb begin
        acc       = event_i & mask_i;
        acc_cnt   = popcount(MAX_SOURCES'(acc));
        pending_d = ack_i ? ((pending_q & ~ack_mask_i) | acc) : (pending_q | acc);
        thresh_hit = (event_count_o >= threshold_i);
        // 33-bit compare so TIMEOUT of 0 or 1 both fire on the next cycle.
        timeout_hit = ((33'(timer_q) + 33'd1) >= 33'(timeout_i));
    end

    irq_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .ADD_WIDTH (POP_W)
    ) u_count (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (ack_i),
        .add_i   (acc_cnt),
        .count_o (event_count_o)
    );

    // Coalescing FSM with window timer, pending bits and registered IRQ.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE_ST;
            timer_q   <= '0;
            irq_q     <= 1'b0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (ack_i) begin
                irq_q   <= 1'b0;
                timer_q <= '0;
                state_q <= (|pending_d) ? COLLECT_ST : IDLE_ST;
            end else begin
                case (state_q)
                    IDLE_ST: begin
                        timer_q <= '0;
                        if (|acc) begin
                            state_q <= COLLECT_ST;
                        end
                    end
                    COLLECT_ST: begin
                        if (thresh_hit || timeout_hit) begin
                            state_q <= ASSERT_ST;
                            irq_q   <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TIMER_W'(1);
                        end
                    end
                    ASSERT_ST: begin
                        irq_q <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE_ST;
                        irq_q   <= 1'b0;
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

    assign pending_o = pending_q;
    assign irq_o     = irq_q;

endmodule
